// File: rtl/demux_1_8_tdm_pkg.sv
// demux_1_8_tdm_pkg: shared TDM framing types, also used by the 8:1 mux transmitter for select encoding
package demux_1_8_tdm_pkg;
  localparam int SLOTS = 8;
  typedef logic [2:0] slot_t;
  typedef enum logic {IDLE, COLLECT} state_t;
endpackage

// File: rtl/demux_1_8_tdm_if.sv
// demux_1_8_tdm_if: TDM receive bus
// slave (demux): takes din/din_valid/sof/frame_ack, drives a..h/frame_valid/slot/sync_err/overrun
// master (link + consumer side): the opposite directions
interface demux_1_8_tdm_if #(parameter int WIDTH = 3);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic sof;
  logic frame_ack;
  logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
  logic frame_valid;
  demux_1_8_tdm_pkg::slot_t slot;
  logic sync_err;
  logic overrun;
  modport slave (
    input din, din_valid, sof, frame_ack,
    output a, b, c, d, e, f, g, h, frame_valid, slot, sync_err, overrun
  );
  modport master (
    output din, din_valid, sof, frame_ack,
    input a, b, c, d, e, f, g, h, frame_valid, slot, sync_err, overrun
  );
endinterface

// File: rtl/demux_slot_counter.sv
// demux_slot_counter: 3-bit wrapping slot index, loads 1 on sof, steps on each data word
// ports: clk, rst_n (async low), load, inc, slot (next slot expected), last (slot==7)
module demux_slot_counter
  import demux_1_8_tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  inc,
  output slot_t slot,
  output logic  last
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) slot <= '0;
    else if (load) slot <= slot_t'(1);
    else if (inc) slot <= slot + slot_t'(1);
  assign last = slot == slot_t'(SLOTS - 1);
endmodule

// File: rtl/demux_1_8_tdm.sv
// demux_1_8_tdm: 1:8 TDM demultiplexer, collects a frame of 8 words and commits it atomically
// ports: clk, rst_n (async low), bus (slave): din/din_valid/sof in, frame_ack in,
//        a..h committed slots 0..7, frame_valid, slot, sync_err pulse, overrun pulse
module demux_1_8_tdm
  import demux_1_8_tdm_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input logic clk,
  input logic rst_n,
  demux_1_8_tdm_if.slave bus
);
  state_t state;
  slot_t slot;
  logic last, load, word, frame_valid, sync_err, overrun;
  // slot 7 is taken straight from din on the commit edge, so only 7 words are buffered
  logic [WIDTH-1:0] shadow [SLOTS-1];
  logic [WIDTH-1:0] out_q [SLOTS];
  assign load = bus.din_valid & bus.sof;
  assign word = bus.din_valid & ~bus.sof & (state == COLLECT);
  demux_slot_counter u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .inc  (word),
    .slot (slot),
    .last (last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < SLOTS; i++) out_q[i] <= '0;
      for (int i = 0; i < SLOTS - 1; i++) shadow[i] <= '0;
    end else begin
      // framing error: sof mid-frame, or a data word with no frame open
      sync_err    <= bus.din_valid & (bus.sof ? state == COLLECT : state == IDLE);
      // an ack on the commit edge consumes the old frame, so no overrun then
      overrun     <= word & last & frame_valid & ~bus.frame_ack;
      frame_valid <= (word & last) | (frame_valid & ~bus.frame_ack);
      if (load) begin
        shadow[0] <= bus.din;
        state     <= COLLECT;
      end else if (word & last) begin
        for (int i = 0; i < SLOTS - 1; i++) out_q[i] <= shadow[i];
        out_q[SLOTS-1] <= bus.din;
        state          <= IDLE;
      end else if (word) shadow[slot] <= bus.din;
    end
  assign bus.a           = out_q[0];
  assign bus.b           = out_q[1];
  assign bus.c           = out_q[2];
  assign bus.d           = out_q[3];
  assign bus.e           = out_q[4];
  assign bus.f           = out_q[5];
  assign bus.g           = out_q[6];
  assign bus.h           = out_q[7];
  assign bus.frame_valid = frame_valid;
  assign bus.slot        = slot;
  assign bus.sync_err    = sync_err;
  assign bus.overrun     = overrun;
endmodule

// File: tb/tb_demux_1_8_tdm.sv
// tb_demux_1_8_tdm: self-checking bench for demux_1_8_tdm against a frame-level model
module tb_demux_1_8_tdm;
  logic clk, rst_n;
  int errors = 0, checks = 0, sync_cnt = 0, ov_cnt = 0;
  demux_1_8_tdm_if #(.WIDTH(3)) bus ();
  demux_1_8_tdm #(.WIDTH(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [23:0] dut_frame;
  assign dut_frame = {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
  // model: frames as packed octal words, slot i in bits [3i+:3]
  logic [23:0] m_frame = '0, m_buf = '0;
  logic m_fv = 1'b0, m_sync = 1'b0, m_ov = 1'b0;
  int m_cnt = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_frame = '0;
      m_buf   = '0;
      m_fv    = 1'b0;
      m_sync  = 1'b0;
      m_ov    = 1'b0;
      m_cnt   = 0;
    end else begin
      logic take, commit;
      take   = m_fv && bus.frame_ack;
      commit = 1'b0;
      m_sync = 1'b0;
      m_ov   = 1'b0;
      if (bus.din_valid) begin
        if (bus.sof) begin
          m_sync = m_cnt != 0;
          m_buf = '0;
          m_buf[2:0] = bus.din;
          m_cnt = 1;
        end else if (m_cnt == 0) m_sync = 1'b1;
        else begin
          m_buf[3*m_cnt+:3] = bus.din;
          m_cnt++;
          if (m_cnt == 8) begin
            m_ov    = m_fv && !bus.frame_ack;
            m_frame = m_buf;
            commit  = 1'b1;
            m_cnt   = 0;
          end
        end
      end
      if (commit) m_fv = 1'b1;
      else if (take) m_fv = 1'b0;
    end
  task automatic chk(input string n, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0o exp=%0o at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("frame", dut_frame, m_frame);
    chk("frame_valid", 24'(bus.frame_valid), 24'(m_fv));
    chk("slot", 24'(bus.slot), 24'(m_cnt));
    chk("sync_err", 24'(bus.sync_err), 24'(m_sync));
    chk("overrun", 24'(bus.overrun), 24'(m_ov));
    if (bus.sync_err === 1'b1) sync_cnt++;
    if (bus.overrun === 1'b1) ov_cnt++;
  end
  task automatic step;
    @(posedge clk);
    #3;
  endtask
  task automatic word(input logic s, input logic [2:0] d, input logic ack);
    bus.din_valid = 1'b1;
    bus.sof = s;
    bus.din = d;
    bus.frame_ack = ack;
    step();
    bus.din_valid = 1'b0;
    bus.sof = 1'b0;
    bus.frame_ack = 1'b0;
  endtask
  task automatic send_frame(input logic [23:0] w, input int gap, input logic ack_last);
    for (int i = 0; i < 8; i++) begin
      word(i == 0, w[3*i+:3], ack_last && i == 7);
      repeat (gap) step();
    end
  endtask
  task automatic ack;
    bus.frame_ack = 1'b1;
    step();
    bus.frame_ack = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.sof = 1'b0;
    bus.frame_ack = 1'b0;
    repeat (2) step();
    chk("reset_frame", dut_frame, 24'o0);
    chk("reset_fv", 24'(bus.frame_valid), 24'd0);
    rst_n = 1'b1;
    step();
    send_frame(24'o76543210, 0, 1'b0);
    chk("t1_frame", dut_frame, 24'o76543210);
    chk("t1_fv", 24'(bus.frame_valid), 24'd1);
    chk("t1_slot", 24'(bus.slot), 24'd0);
    ack();
    chk("t1_ack_fv", 24'(bus.frame_valid), 24'd0);
    send_frame(24'o76543210, 2, 1'b0);
    chk("t2_frame", dut_frame, 24'o76543210);
    chk("t2_sync_cnt", 24'(sync_cnt), 24'd0);
    ack();
    word(1'b1, 3'd1, 1'b0);
    word(1'b0, 3'd2, 1'b0);
    word(1'b0, 3'd3, 1'b0);
    send_frame(24'o67012345, 0, 1'b0);
    chk("t3_frame", dut_frame, 24'o67012345);
    chk("t3_sync_cnt", 24'(sync_cnt), 24'd1);
    ack();
    word(1'b0, 3'd3, 1'b0);
    chk("t4_sync_pulse", 24'(bus.sync_err), 24'd1);
    step();
    chk("t4_sync_cnt", 24'(sync_cnt), 24'd2);
    chk("t4_frame", dut_frame, 24'o67012345);
    chk("t4_slot", 24'(bus.slot), 24'd0);
    send_frame(24'o76543210, 0, 1'b0);
    send_frame(24'o67012345, 0, 1'b0);
    chk("t5_ov_pulse", 24'(bus.overrun), 24'd1);
    send_frame(24'o12345670, 0, 1'b1);
    chk("t5_no_ov", 24'(bus.overrun), 24'd0);
    chk("t5_fv", 24'(bus.frame_valid), 24'd1);
    chk("t5_frame", dut_frame, 24'o12345670);
    step();
    chk("t5_ov_cnt", 24'(ov_cnt), 24'd1);
    for (int i = 0; i < 4; i++) word(i == 0, 3'(i + 4), 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_frame", dut_frame, 24'o0);
    chk("t6_rst_fv", 24'(bus.frame_valid), 24'd0);
    chk("t6_rst_slot", 24'(bus.slot), 24'd0);
    step();
    rst_n = 1'b1;
    step();
    send_frame(24'o76543210, 0, 1'b0);
    chk("t6_frame", dut_frame, 24'o76543210);
    chk("t6_fv", 24'(bus.frame_valid), 24'd1);
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
